// File: rtl/call_stack_pkg.sv
// Shared CPU parameter package: datapath widths, return-stack sizing and the
// stack-operation decode used by the return-address stack.
package call_stack_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int DATA_WIDTH      = 8;
    localparam int CPU_CNTR_WIDTH  = 8;
    localparam int CPU_REG_BIT_CNT = 3;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_REPL  = 3'd3,
        OP_FLUSH = 3'd4
    } stack_op_e;

    // Flush dominates; CALL+RET together is a tail-call style replace.
    function automatic stack_op_e decode_op(input logic flush,
                                            input logic cal_f,
                                            input logic ret_f);
        stack_op_e op;
        if (flush) begin
            op = OP_FLUSH;
        end else begin
            case ({cal_f, ret_f})
                2'b10:   op = OP_PUSH;
                2'b01:   op = OP_POP;
                2'b11:   op = OP_REPL;
                default: op = OP_HOLD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; control logic masks stale data.
module call_stack_mem #(
    parameter int ADDR_BITS = 3,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: circular array with a top pointer, depth
// counter and sticky overflow/underflow flags. Top of stack is read with zero latency.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int CNTR_WIDTH  = CPU_CNTR_WIDTH,
    parameter int REG_BIT_CNT = CPU_REG_BIT_CNT,
    parameter int OVF_WRAP    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cal_f,
    input  logic                   ret_f,
    input  logic                   flush,
    input  logic [CNTR_WIDTH-1:0]  counter,
    output logic [CNTR_WIDTH-1:0]  ret_addr,
    output logic [REG_BIT_CNT:0]   depth,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf_err,
    output logic                   unf_err
);

    localparam logic [REG_BIT_CNT:0]   DEPTH_MAX  = (REG_BIT_CNT+1)'(1 << REG_BIT_CNT);
    localparam logic [REG_BIT_CNT:0]   DEPTH_ZERO = {(REG_BIT_CNT+1){1'b0}};
    localparam logic [REG_BIT_CNT:0]   DEPTH_ONE  = (REG_BIT_CNT+1)'(1);
    localparam logic [REG_BIT_CNT-1:0] PTR_ZERO   = {REG_BIT_CNT{1'b0}};
    localparam logic [REG_BIT_CNT-1:0] PTR_ONE    = REG_BIT_CNT'(1);

    logic [REG_BIT_CNT-1:0] top_r;
    logic [REG_BIT_CNT:0]   depth_r;
    logic                   empty_r;
    logic                   full_r;
    logic                   ovf_r;
    logic                   unf_r;

    stack_op_e              op_s;
    logic [REG_BIT_CNT-1:0] top_nxt_s;
    logic [REG_BIT_CNT:0]   depth_nxt_s;
    logic                   we_s;
    logic [REG_BIT_CNT-1:0] waddr_s;
    logic                   ovf_set_s;
    logic                   unf_set_s;
    logic [CNTR_WIDTH-1:0]  rdata_s;

    assign op_s = decode_op(flush, cal_f, ret_f);

    // Next-state decode for pointer, depth, array write and error flags
    always_comb begin
        top_nxt_s   = top_r;
        depth_nxt_s = depth_r;
        we_s        = 1'b0;
        waddr_s     = top_r + PTR_ONE;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case (op_s)
            OP_FLUSH: begin
                top_nxt_s   = PTR_ZERO;
                depth_nxt_s = DEPTH_ZERO;
            end
            OP_PUSH: begin
                if (!full_r) begin
                    we_s        = 1'b1;
                    top_nxt_s   = top_r + PTR_ONE;
                    depth_nxt_s = depth_r + DEPTH_ONE;
                end else if (OVF_WRAP != 0) begin
                    // Slot top+1 holds the oldest entry once the ring is full.
                    we_s      = 1'b1;
                    top_nxt_s = top_r + PTR_ONE;
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_r) begin
                    top_nxt_s   = top_r - PTR_ONE;
                    depth_nxt_s = depth_r - DEPTH_ONE;
                end else begin
                    unf_set_s = 1'b1;
                end
            end
            OP_REPL: begin
                if (!empty_r) begin
                    we_s    = 1'b1;
                    waddr_s = top_r;
                end else begin
                    we_s        = 1'b1;
                    top_nxt_s   = top_r + PTR_ONE;
                    depth_nxt_s = depth_r + DEPTH_ONE;
                    unf_set_s   = 1'b1;
                end
            end
            default: begin
                top_nxt_s   = top_r;
                depth_nxt_s = depth_r;
            end
        endcase
    end

    // Control state; empty/full are registered alongside depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_r   <= PTR_ZERO;
            depth_r <= DEPTH_ZERO;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            top_r   <= top_nxt_s;
            depth_r <= depth_nxt_s;
            empty_r <= (depth_nxt_s == DEPTH_ZERO);
            full_r  <= (depth_nxt_s == DEPTH_MAX);
            ovf_r   <= ovf_r | ovf_set_s;
            unf_r   <= unf_r | unf_set_s;
        end
    end

    call_stack_mem #(
        .ADDR_BITS (REG_BIT_CNT),
        .WIDTH     (CNTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (counter),
        .raddr (top_r),
        .rdata (rdata_s)
    );

    // Stale array contents never escape when the stack is empty.
    assign ret_addr = empty_r ? {CNTR_WIDTH{1'b0}} : rdata_s;
    assign depth    = depth_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign ovf_err  = ovf_r;
    assign unf_err  = unf_r;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: reject (u0) and wrap (u1) overflow variants driven in
// parallel, checked every cycle against queue models plus literal expectations.
module tb_call_stack;

    typedef logic [7:0] q_t [$];

    logic       clk;
    logic       rst_n;
    logic       cal_f;
    logic       ret_f;
    logic       flush;
    logic [7:0] counter;

    logic [7:0] ret_addr0, ret_addr1;
    logic [3:0] depth0, depth1;
    logic       empty0, empty1, full0, full1;
    logic       ovf0, ovf1, unf0, unf1;

    int checks   = 0;
    int failures = 0;

    q_t   q0, q1;
    logic mo0, mu0, mo1, mu1;

    call_stack #(.CNTR_WIDTH(8), .REG_BIT_CNT(3), .OVF_WRAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .cal_f(cal_f), .ret_f(ret_f), .flush(flush),
        .counter(counter), .ret_addr(ret_addr0), .depth(depth0), .empty(empty0),
        .full(full0), .ovf_err(ovf0), .unf_err(unf0)
    );

    call_stack #(.CNTR_WIDTH(8), .REG_BIT_CNT(3), .OVF_WRAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cal_f(cal_f), .ret_f(ret_f), .flush(flush),
        .counter(counter), .ret_addr(ret_addr1), .depth(depth1), .empty(empty1),
        .full(full1), .ovf_err(ovf1), .unf_err(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A LIFO of at most 8 entries, expressed with queue operations.
    task automatic model_step(inout q_t q, inout logic ovf, inout logic unf, input bit wrap);
        if (flush) begin
            q.delete();
        end else if (cal_f && ret_f) begin
            if (q.size() > 0) begin
                q[q.size()-1] = counter;
            end else begin
                q.push_back(counter);
                unf = 1'b1;
            end
        end else if (cal_f) begin
            if (q.size() < 8) begin
                q.push_back(counter);
            end else begin
                ovf = 1'b1;
                if (wrap) begin
                    void'(q.pop_front());
                    q.push_back(counter);
                end
            end
        end else if (ret_f) begin
            if (q.size() > 0) void'(q.pop_back());
            else unf = 1'b1;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mo0 = 1'b0; mu0 = 1'b0; mo1 = 1'b0; mu1 = 1'b0;
    endtask

    task automatic cmp_dut(input string tag, input q_t q, input logic mo, input logic mu,
                           input logic [7:0] ra, input logic [3:0] d, input logic e,
                           input logic f, input logic ov, input logic un);
        logic [7:0] exp_ra;
        exp_ra = (q.size() > 0) ? q[q.size()-1] : 8'h00;
        chk({tag, "_ret_addr"}, {24'd0, ra}, {24'd0, exp_ra});
        chk({tag, "_depth"},    {28'd0, d},  q.size());
        chk({tag, "_empty"},    {31'd0, e},  {31'd0, q.size() == 0});
        chk({tag, "_full"},     {31'd0, f},  {31'd0, q.size() == 8});
        chk({tag, "_ovf_err"},  {31'd0, ov}, {31'd0, mo});
        chk({tag, "_unf_err"},  {31'd0, un}, {31'd0, mu});
    endtask

    // Every-cycle comparison on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            cmp_dut("u0", q0, mo0, mu0, ret_addr0, depth0, empty0, full0, ovf0, unf0);
            cmp_dut("u1", q1, mo1, mu1, ret_addr1, depth1, empty1, full1, ovf1, unf1);
        end
    end

    // Apply one cycle of stimulus; returns at posedge+1 with inputs idle.
    task automatic op(input logic c, input logic r, input logic f, input logic [7:0] v);
        cal_f = c; ret_f = r; flush = f; counter = v;
        @(posedge clk);
        model_step(q0, mo0, mu0, 1'b0);
        model_step(q1, mo1, mu1, 1'b1);
        #1;
        cal_f = 1'b0; ret_f = 1'b0; flush = 1'b0; counter = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; cal_f = 1'b0; ret_f = 1'b0; flush = 1'b0; counter = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_ret_addr", {24'd0, ret_addr0}, 32'h0);
        chk("rst_empty", {31'd0, empty0}, 32'd1);
        chk("rst_full", {31'd0, full0}, 32'd0);
        chk("rst_depth", {28'd0, depth0}, 32'd0);

        // Push three, pop three
        op(1'b1, 1'b0, 1'b0, 8'h10);
        op(1'b1, 1'b0, 1'b0, 8'h20);
        op(1'b1, 1'b0, 1'b0, 8'h30);
        chk("push3_depth", {28'd0, depth0}, 32'd3);
        chk("push3_ret", {24'd0, ret_addr0}, 32'h30);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop1_ret", {24'd0, ret_addr0}, 32'h20);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop2_ret", {24'd0, ret_addr0}, 32'h10);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop3_ret", {24'd0, ret_addr0}, 32'h00);
        chk("pop3_empty", {31'd0, empty0}, 32'd1);

        // Underflow is sticky
        op(1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf_flag", {31'd0, unf0}, 32'd1);
        chk("unf_depth", {28'd0, depth0}, 32'd0);
        chk("unf_ret", {24'd0, ret_addr0}, 32'h0);
        op(1'b1, 1'b0, 1'b0, 8'h77);
        chk("unf_sticky", {31'd0, unf0}, 32'd1);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Fill, then overflow both variants
        for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 1'b0, 8'(i));
        op(1'b1, 1'b0, 1'b0, 8'h09);
        chk("ovf0_full", {31'd0, full0}, 32'd1);
        chk("ovf0_depth", {28'd0, depth0}, 32'd8);
        chk("ovf0_ret", {24'd0, ret_addr0}, 32'h08);
        chk("ovf0_flag", {31'd0, ovf0}, 32'd1);
        chk("ovf1_ret", {24'd0, ret_addr1}, 32'h09);
        chk("ovf1_depth", {28'd0, depth1}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_pop_ret", {24'd0, ret_addr1}, 32'(9 - i));
            chk("rej_pop_ret", {24'd0, ret_addr0}, 32'(8 - i));
            op(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("drain_empty", {31'd0, empty1}, 32'd1);

        // CALL+RET replaces top
        op(1'b1, 1'b0, 1'b0, 8'h10);
        op(1'b1, 1'b0, 1'b0, 8'h20);
        op(1'b1, 1'b1, 1'b0, 8'h55);
        chk("repl_depth", {28'd0, depth0}, 32'd2);
        chk("repl_ret", {24'd0, ret_addr0}, 32'h55);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        chk("repl_pop_ret", {24'd0, ret_addr0}, 32'h10);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush beats a simultaneous CALL; flags survive
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h31 + i));
        chk("pre_flush_depth", {28'd0, depth0}, 32'd5);
        op(1'b1, 1'b0, 1'b1, 8'hAA);
        chk("flush_depth", {28'd0, depth0}, 32'd0);
        chk("flush_empty", {31'd0, empty0}, 32'd1);
        chk("flush_ret", {24'd0, ret_addr0}, 32'h0);
        chk("flush_ovf", {31'd0, ovf0}, 32'd1);
        chk("flush_unf", {31'd0, unf0}, 32'd1);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, 8'(8'h41 + i));
        chk("pre_rst_depth", {28'd0, depth0}, 32'd4);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_depth", {28'd0, depth0}, 32'd0);
        chk("arst_ret", {24'd0, ret_addr0}, 32'h0);
        chk("arst_empty", {31'd0, empty0}, 32'd1);
        chk("arst_ovf", {31'd0, ovf0}, 32'd0);
        chk("arst_unf", {31'd0, unf1}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // CALL+RET on empty pushes and flags underflow
        op(1'b1, 1'b1, 1'b0, 8'h66);
        chk("cr_empty_depth", {28'd0, depth0}, 32'd1);
        chk("cr_empty_ret", {24'd0, ret_addr0}, 32'h66);
        chk("cr_empty_unf", {31'd0, unf0}, 32'd1);
        chk("cr_empty_ovf", {31'd0, ovf0}, 32'd0);
        op(1'b0, 1'b0, 1'b0, 8'h99);
        op(1'b0, 1'b0, 1'b0, 8'h99);
        chk("hold_depth", {28'd0, depth0}, 32'd1);
        chk("hold_ret", {24'd0, ret_addr1}, 32'h66);

        // Mixed traffic, checked by the per-cycle compare
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 31) == 0), 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
